// File: rtl/m3_six_step_gen_pkg.sv
// Shared definitions for the six-step generator: FSM encodings, per-phase
// drive codes and the commutation table.
package m3_six_step_gen_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic [1:0] {
    PH_Z = 2'd0,
    PH_H = 2'd1,
    PH_L = 2'd2
  } phase_e;

  typedef struct packed {
    phase_e a;
    phase_e b;
    phase_e c;
  } phases_t;

  function automatic phases_t step_phases(input logic [2:0] step);
    phases_t p;
    case (step)
      3'd0:    p = '{a: PH_H, b: PH_L, c: PH_Z};
      3'd1:    p = '{a: PH_H, b: PH_Z, c: PH_L};
      3'd2:    p = '{a: PH_Z, b: PH_H, c: PH_L};
      3'd3:    p = '{a: PH_L, b: PH_H, c: PH_Z};
      3'd4:    p = '{a: PH_L, b: PH_Z, c: PH_H};
      3'd5:    p = '{a: PH_Z, b: PH_L, c: PH_H};
      default: p = '{a: PH_Z, b: PH_Z, c: PH_Z};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/m3_six_step_gen_dead_time.sv
// One half-bridge leg: drops both gates on any change of the desired state and
// re-asserts the matching gate only after DEAD_CYC quiet clocks.
module m3_six_step_gen_dead_time
  import m3_six_step_gen_pkg::*;
#(
  parameter int DEAD_CYC = 10
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_clr,
  input  phase_e i_des,
  output logic   o_hp,
  output logic   o_ln
);

  localparam int CW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  phase_e        r_des;
  logic [CW-1:0] r_cnt;
  logic          r_pend;
  logic          r_hp;
  logic          r_ln;

  // Gates are only ever set one at a time and any change clears both,
  // so HP and LN can never overlap.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_des  <= PH_Z;
      r_cnt  <= '0;
      r_pend <= 1'b0;
      r_hp   <= 1'b0;
      r_ln   <= 1'b0;
    end else if (i_des != r_des) begin
      r_des  <= i_des;
      r_hp   <= 1'b0;
      r_ln   <= 1'b0;
      r_pend <= (i_des == PH_H) || (i_des == PH_L);
      r_cnt  <= CW'(DEAD_CYC - 1);
    end else if (r_pend) begin
      if (r_cnt == '0) begin
        r_pend <= 1'b0;
        r_hp   <= (r_des == PH_H);
        r_ln   <= (r_des == PH_L);
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_hp = r_hp;
  assign o_ln = r_ln;

endmodule

// File: rtl/m3_six_step_gen.sv
// Six-step commutation generator: start/stop FSM, linear frequency ramp,
// phase accumulator driving the step index, and three dead-time legs.
module m3_six_step_gen
  import m3_six_step_gen_pkg::*;
#(
  parameter int FREQ_W    = 10,
  parameter int ACC_W     = 24,
  parameter int DEAD_CYC  = 10,
  parameter int RAMP_DIV  = 1000,
  parameter int RAMP_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m3start,
  input  logic              m3forceStop,
  input  logic              m3invRotate,
  input  logic [FREQ_W-1:0] m3freq,
  output logic              aHP,
  output logic              bHP,
  output logic              cHP,
  output logic              aLN,
  output logic              bLN,
  output logic              cLN,
  output logic              busy,
  output logic [2:0]        stepIdx
);

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int SW = ((ACC_W > FREQ_W) ? ACC_W : FREQ_W) + 1;
  localparam logic [FREQ_W:0] STEP_X = (FREQ_W + 1)'(RAMP_STEP);

  logic [0:0]        r_state;
  logic [2:0]        r_step;
  logic [FREQ_W-1:0] r_cur_freq;
  logic [ACC_W-1:0]  r_acc;
  logic [RW-1:0]     r_rc;

  logic [0:0]        w_state_nxt;
  logic [2:0]        w_step_nxt;
  logic [FREQ_W-1:0] w_cur_nxt;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [RW-1:0]     w_rc_nxt;

  logic [FREQ_W-1:0] w_target;
  logic [FREQ_W-1:0] w_cur_ramp;
  logic [FREQ_W:0]   w_up;
  logic [FREQ_W-1:0] w_gap;
  logic [SW-1:0]     w_sum;
  logic              w_carry;
  logic [2:0]        w_step_adv;
  logic              w_clr;
  phases_t           w_phases;

  assign w_target = m3start ? m3freq : '0;
  assign w_sum    = SW'(r_acc) + SW'(r_cur_freq);
  assign w_carry  = |w_sum[SW-1:ACC_W];

  assign w_step_adv = m3invRotate ? ((r_step == 3'd0) ? 3'd5 : r_step - 3'd1)
                                  : ((r_step == 3'd5) ? 3'd0 : r_step + 3'd1);

  // Saturate exactly at the target in both directions; the extra bit on w_up
  // keeps the upward compare safe near the top of the range.
  always_comb begin
    w_cur_ramp = r_cur_freq;
    w_up       = {1'b0, r_cur_freq} + STEP_X;
    w_gap      = r_cur_freq - w_target;
    if (r_cur_freq < w_target) begin
      w_cur_ramp = (w_up >= {1'b0, w_target}) ? w_target : w_up[FREQ_W-1:0];
    end else if (r_cur_freq > w_target) begin
      w_cur_ramp = ({1'b0, w_gap} <= STEP_X) ? w_target
                                             : r_cur_freq - STEP_X[FREQ_W-1:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_cur_nxt   = r_cur_freq;
    w_acc_nxt   = r_acc;
    w_rc_nxt    = r_rc;
    if (r_state == ST_IDLE) begin
      if (m3start && !m3forceStop && (m3freq != '0)) begin
        w_state_nxt = ST_RUN;
        w_step_nxt  = 3'd0;
        w_cur_nxt   = '0;
        w_acc_nxt   = '0;
        w_rc_nxt    = '0;
      end
    end else begin
      if (m3forceStop || ((w_target == '0) && (r_cur_freq == '0))) begin
        w_state_nxt = ST_IDLE;
      end else begin
        w_acc_nxt = w_sum[ACC_W-1:0];
        if (w_carry) begin
          w_step_nxt = w_step_adv;
        end
        if (r_rc == RW'(RAMP_DIV - 1)) begin
          w_rc_nxt  = '0;
          w_cur_nxt = w_cur_ramp;
        end else begin
          w_rc_nxt = r_rc + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_step     <= 3'd0;
      r_cur_freq <= '0;
      r_acc      <= '0;
      r_rc       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_step     <= w_step_nxt;
      r_cur_freq <= w_cur_nxt;
      r_acc      <= w_acc_nxt;
      r_rc       <= w_rc_nxt;
    end
  end

  // Legs see the next step so off-going gates drop on the same edge the index moves.
  assign w_phases = step_phases(w_step_nxt);
  assign w_clr    = (w_state_nxt == ST_IDLE);

  m3_six_step_gen_dead_time #(.DEAD_CYC(DEAD_CYC)) u_dt_a (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_clr),
    .i_des(w_phases.a),
    .o_hp (aHP),
    .o_ln (aLN)
  );

  m3_six_step_gen_dead_time #(.DEAD_CYC(DEAD_CYC)) u_dt_b (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_clr),
    .i_des(w_phases.b),
    .o_hp (bHP),
    .o_ln (bLN)
  );

  m3_six_step_gen_dead_time #(.DEAD_CYC(DEAD_CYC)) u_dt_c (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_clr),
    .i_des(w_phases.c),
    .o_hp (cHP),
    .o_ln (cLN)
  );

  assign busy    = (r_state == ST_RUN);
  assign stepIdx = r_step;

endmodule

// File: tb/tb_m3_six_step_gen.sv
// Directed plus random bench for m3_six_step_gen with a cycle model feeding
// an expected-output queue.
module tb_m3_six_step_gen;

  localparam int FW = 8;
  localparam int AW = 8;
  localparam int DC = 2;
  localparam int RD = 2;
  localparam int RS = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          m3start;
  logic          m3forceStop;
  logic          m3invRotate;
  logic [FW-1:0] m3freq;
  logic          aHP, bHP, cHP, aLN, bLN, cLN, busy;
  logic [2:0]    stepIdx;
  logic [9:0]    obs;

  always #5 clk = ~clk;

  m3_six_step_gen #(
    .FREQ_W(FW), .ACC_W(AW), .DEAD_CYC(DC), .RAMP_DIV(RD), .RAMP_STEP(RS)
  ) u_dut (
    .clk(clk), .rst(rst), .m3start(m3start), .m3forceStop(m3forceStop),
    .m3invRotate(m3invRotate), .m3freq(m3freq),
    .aHP(aHP), .bHP(bHP), .cHP(cHP), .aLN(aLN), .bLN(bLN), .cLN(cLN),
    .busy(busy), .stepIdx(stepIdx)
  );

  assign obs = {busy, stepIdx, aHP, aLN, bHP, bLN, cHP, cLN};

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] exp_q[$];

  // Model state: run flag, step, curFreq, accumulator, ramp counter, and per
  // phase the desired code (0 Z, 1 H, 2 L) and clocks since it last changed.
  int m_run, m_step, m_cur, m_acc, m_rc;
  int m_des[3];
  int m_age[3];
  int tbl[6][3] = '{'{1, 2, 0}, '{1, 0, 2}, '{0, 1, 2},
                    '{2, 1, 0}, '{2, 0, 1}, '{0, 2, 1}};

  task automatic check(input string tag, input int o, input int e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_step();
    int tgt, s, nd;
    if (rst) begin
      m_run = 0; m_step = 0; m_cur = 0; m_acc = 0; m_rc = 0;
      for (int p = 0; p < 3; p++) begin m_des[p] = 0; m_age[p] = 0; end
    end else begin
      tgt = m3start ? int'(m3freq) : 0;
      if (m_run == 0) begin
        if (m3start && !m3forceStop && m3freq != 0) begin
          m_run = 1; m_acc = 0; m_step = 0; m_cur = 0; m_rc = 0;
        end
      end else if (m3forceStop || (tgt == 0 && m_cur == 0)) begin
        m_run = 0;
      end else begin
        s = m_acc + m_cur;
        if (s >= (1 << AW)) m_step = m3invRotate ? (m_step + 5) % 6 : (m_step + 1) % 6;
        m_acc = s % (1 << AW);
        if (m_rc == RD - 1) begin
          m_rc = 0;
          if (m_cur < tgt) m_cur = (m_cur + RS > tgt) ? tgt : m_cur + RS;
          else if (m_cur > tgt) m_cur = (m_cur - RS < tgt) ? tgt : m_cur - RS;
        end else begin
          m_rc++;
        end
      end
      for (int p = 0; p < 3; p++) begin
        nd = (m_run != 0) ? tbl[m_step][p] : 0;
        if (nd != m_des[p]) begin m_des[p] = nd; m_age[p] = 0; end
        else if (m_age[p] < DC) m_age[p]++;
      end
    end
  endtask

  function automatic logic [9:0] model_out();
    logic [9:0] o;
    logic [2:0] st;
    st = m_step[2:0];
    o = '0;
    o[9] = (m_run != 0);
    o[8:6] = st;
    for (int p = 0; p < 3; p++) begin
      o[5-2*p] = (m_des[p] == 1) && (m_age[p] >= DC);
      o[4-2*p] = (m_des[p] == 2) && (m_age[p] >= DC);
    end
    return o;
  endfunction

  task automatic tick(input string tag);
    logic [9:0] e;
    model_step();
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, int'(obs), int'(e));
    check("no_overlap", int'({aHP & aLN, bHP & bLN, cHP & cLN}), 0);
  endtask

  task automatic wait_step(input string tag);
    logic [2:0] prev;
    int n;
    prev = stepIdx;
    n = 0;
    do begin
      tick(tag);
      n++;
    end while (stepIdx == prev && n < 12);
    check({tag, "_sync"}, int'(stepIdx != prev), 1);
  endtask

  task automatic measure_steps(input string tag, input int dir);
    logic [2:0] prev;
    int n;
    for (int k = 0; k < 3; k++) begin
      prev = stepIdx;
      n = 0;
      do begin
        tick(tag);
        n++;
      end while (stepIdx == prev && n < 12);
      check({tag, "_period"}, n, 4);
      check({tag, "_next"}, int'(stepIdx), (int'(prev) + dir + 6) % 6);
    end
  endtask

  initial begin
    rst = 1'b1; m3start = 1'b0; m3forceStop = 1'b0; m3invRotate = 1'b0; m3freq = '0;
    repeat (3) tick("reset");
    check("reset_outputs", int'(obs), 0);
    rst = 1'b0;
    repeat (2) tick("idle");

    // Zero frequency command must not start the motor.
    m3start = 1'b1;
    repeat (5) tick("zero_freq");
    check("zero_freq_idle", int'(obs), 0);

    m3start = 1'b0; m3freq = 8'd64;
    tick("pre_start");
    m3start = 1'b1;
    tick("start");
    check("start_busy", int'(obs), int'(10'b1_000_000000));
    tick("start_dead");
    check("start_dead_gates", int'(obs), int'(10'b1_000_000000));
    tick("start_on");
    check("start_gates_on", int'(obs), int'(10'b1_000_100100));

    repeat (60) tick("ramp_up");
    wait_step("fwd");
    measure_steps("fwd", 1);

    m3invRotate = 1'b1;
    wait_step("rev");
    measure_steps("rev", 5);

    // Force stop from a running state, then hold start with force asserted.
    m3forceStop = 1'b1;
    tick("force");
    check("force_off", int'({obs[9], obs[5:0]}), 0);
    repeat (3) tick("force_hold");
    check("force_hold_idle", int'(busy), 0);
    m3forceStop = 1'b0; m3invRotate = 1'b0; m3freq = 8'd10;
    tick("restart");
    check("restart_busy", int'(busy), 1);
    repeat (20) tick("ramp_10");

    m3start = 1'b0;
    for (int n = 0; n < 20 && busy; n++) tick("ramp_down");
    check("ramp_down_stop", int'(obs[9]), 0);
    check("ramp_down_gates", int'(obs[5:0]), 0);

    // Random stress with occasional force stops, resets and retargets.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      m3forceStop = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 39) == 0) m3start = ~m3start;
      if ($urandom_range(0, 49) == 0) m3invRotate = ~m3invRotate;
      if ($urandom_range(0, 59) == 0) m3freq = FW'($urandom_range(0, 255));
      tick("stress");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
